// File: rtl/cmd_sequencer.sv
// Host-command front end: frames 5-byte commands (sync, opcode, 16-bit arg, XOR checksum),
// validates them, updates trigger/divider configuration and sequences arm/abort pulses.
module cmd_sequencer #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hAB,
  parameter int unsigned TIMEOUT     = 50000,
  parameter logic [15:0] DIV_DEFAULT = 16'd1
) (
  input  logic        rdclk,
  input  logic        nreset,
  input  logic        en,
  input  logic [7:0]  rx_byte,
  input  logic        ready,
  input  logic        capture_busy,
  output logic [7:0]  trig_mask,
  output logic [7:0]  trig_value,
  output logic [15:0] clk_div,
  output logic        arm,
  output logic        abort,
  output logic        cmd_ok,
  output logic        frame_err,
  output logic [2:0]  err_code
);

  typedef enum logic [2:0] {IDLE, OP, AHI, ALO, CHK, EXEC} state_t;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t        state, next;
  logic [1:0]    rdy;
  logic          stb, in_frame, tmo, sum_ok;
  logic [CW-1:0] cnt;
  logic [7:0]    op;
  logic [15:0]   arg;

  logic [7:0]  mask_d, value_d;
  logic [15:0] div_d;
  logic [2:0]  code_d;
  logic        arm_d, abort_d, ok_d, err_d;

  // rdy[1] is the newest sample; stb fires one cycle after ready rises
  always_ff @(posedge rdclk) begin
    if (!nreset)  rdy <= '0;
    else if (en)  rdy <= {ready, rdy[1]};
  end

  assign stb      = en & rdy[1] & ~rdy[0];
  assign in_frame = (state == OP) || (state == AHI) || (state == ALO) || (state == CHK);
  assign tmo      = en & in_frame & ~stb & (cnt == CW'(TIMEOUT - 1));
  assign sum_ok   = (rx_byte == (op ^ arg[15:8] ^ arg[7:0]));

  always_ff @(posedge rdclk) begin
    if (!nreset)  state <= IDLE;
    else if (en)  state <= next;
  end

  always_ff @(posedge rdclk) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (en) begin
      if (!in_frame || stb || tmo) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge rdclk) begin
    if (!nreset) begin
      op  <= '0;
      arg <= '0;
    end else if (stb) begin
      case (state)
        OP:      op        <= rx_byte;
        AHI:     arg[15:8] <= rx_byte;
        ALO:     arg[7:0]  <= rx_byte;
        default: ;
      endcase
    end
  end

  always_comb begin
    next = state;
    if (tmo) begin
      next = IDLE;
    end else if (stb) begin
      case (state)
        IDLE:    if (rx_byte == SYNC_BYTE) next = OP;
        OP:      next = AHI;
        AHI:     next = ALO;
        ALO:     next = CHK;
        CHK:     next = sum_ok ? EXEC : IDLE;
        default: next = IDLE;
      endcase
    end else if (state == EXEC) begin
      next = IDLE;
    end
  end

  // Computes next values of the registered outputs; nothing fires while en is low
  always_comb begin
    mask_d  = trig_mask;
    value_d = trig_value;
    div_d   = clk_div;
    code_d  = err_code;
    arm_d   = 1'b0;
    abort_d = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    if (tmo) begin
      err_d  = 1'b1;
      code_d = 3'd3;
    end else if (stb && state == CHK && !sum_ok) begin
      err_d  = 1'b1;
      code_d = 3'd1;
    end else if (en && state == EXEC) begin
      ok_d   = 1'b1;
      code_d = 3'd0;
      case (op)
        8'h01: mask_d  = arg[7:0];
        8'h02: value_d = arg[7:0];
        8'h03: div_d   = (arg == '0) ? 16'd1 : arg;
        8'h04: begin
          if (capture_busy) begin
            ok_d   = 1'b0;
            err_d  = 1'b1;
            code_d = 3'd4;
          end else begin
            arm_d = 1'b1;
          end
        end
        8'h05: abort_d = 1'b1;
        default: begin
          ok_d   = 1'b0;
          err_d  = 1'b1;
          code_d = 3'd2;
        end
      endcase
    end
  end

  always_ff @(posedge rdclk) begin
    if (!nreset) begin
      trig_mask  <= '0;
      trig_value <= '0;
      clk_div    <= DIV_DEFAULT;
      err_code   <= '0;
      arm        <= 1'b0;
      abort      <= 1'b0;
      cmd_ok     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      trig_mask  <= mask_d;
      trig_value <= value_d;
      clk_div    <= div_d;
      err_code   <= code_d;
      arm        <= arm_d;
      abort      <= abort_d;
      cmd_ok     <= ok_d;
      frame_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: the stimulus side predicts each frame's outcome and due cycle,
// a negedge monitor pops and compares whenever a result pulse appears.
module tb_cmd_sequencer;

  localparam logic [7:0] SYNC = 8'hAB;
  localparam int unsigned TMO = 20;

  logic        rdclk = 1'b0;
  logic        nreset, en, ready, capture_busy;
  logic [7:0]  rx_byte;
  logic [7:0]  trig_mask, trig_value;
  logic [15:0] clk_div;
  logic        arm, abort, cmd_ok, frame_err;
  logic [2:0]  err_code;

  typedef struct packed {
    logic        ok;
    logic        err;
    logic        arm;
    logic        abort;
    logic [2:0]  code;
    logic [7:0]  mask;
    logic [7:0]  value;
    logic [15:0] div;
  } resp_t;

  resp_t       exp_q[$];
  int unsigned due_q[$];
  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  // reference state of the configuration registers
  logic [7:0]  m_mask, m_value;
  logic [15:0] m_div;
  logic [2:0]  m_code;

  cmd_sequencer #(.SYNC_BYTE(SYNC), .TIMEOUT(TMO), .DIV_DEFAULT(16'd1)) dut (
    .rdclk(rdclk), .nreset(nreset), .en(en), .rx_byte(rx_byte), .ready(ready),
    .capture_busy(capture_busy), .trig_mask(trig_mask), .trig_value(trig_value),
    .clk_div(clk_div), .arm(arm), .abort(abort), .cmd_ok(cmd_ok),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 rdclk = ~rdclk;
  always @(posedge rdclk) cyc = cyc + 1;

  always @(negedge rdclk) begin
    resp_t       act, e;
    int unsigned d;
    if (cmd_ok || frame_err || arm || abort) begin
      act = '{cmd_ok, frame_err, arm, abort, err_code, trig_mask, trig_value, clk_div};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse: got %h at cycle %0d, required no pulse", act, cyc);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if (act !== e || cyc != d) begin
          mismatched++;
          $display("FAIL response: got %h at cycle %0d, required %h at cycle %0d", act, cyc, e, d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic push(input logic ok, input logic err, input logic a, input logic ab,
                      input int unsigned due);
    exp_q.push_back('{ok, err, a, ab, m_code, m_mask, m_value, m_div});
    due_q.push_back(due);
  endtask

  // raise ready with a byte; n is the cycle number in which ready went high
  task automatic raise(input logic [7:0] b, output int unsigned n);
    @(posedge rdclk); #1;
    rx_byte = b;
    ready   = 1'b1;
    n       = cyc;
  endtask

  task automatic finish_byte();
    @(posedge rdclk); @(posedge rdclk); #1;
    ready = 1'b0;
    @(posedge rdclk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    raise(b, n);
    finish_byte();
  endtask

  task automatic model_reset();
    m_mask = 8'h00; m_value = 8'h00; m_div = 16'h0001; m_code = 3'd0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge rdclk);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    due_q.delete();
  endtask

  // pause > 0 drops en for that many cycles after the opcode byte
  task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input bit good,
                            input bit busy, input int pause);
    logic [7:0]  sum, want;
    int unsigned n;
    capture_busy = busy;
    want = op ^ a[15:8] ^ a[7:0];
    sum  = good ? want : want ^ 8'($urandom_range(1, 255));
    send_byte(SYNC);
    send_byte(op);
    if (pause > 0) begin
      @(posedge rdclk); #1 en = 1'b0;
      repeat (pause) @(posedge rdclk);
      #1 en = 1'b1;
    end
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    raise(sum, n);
    if (sum != want) begin
      m_code = 3'd1;
      push(1'b0, 1'b1, 1'b0, 1'b0, n + 2);
    end else begin
      case (op)
        8'h01: begin m_mask  = a[7:0]; m_code = 3'd0; push(1, 0, 0, 0, n + 3); end
        8'h02: begin m_value = a[7:0]; m_code = 3'd0; push(1, 0, 0, 0, n + 3); end
        8'h03: begin m_div = (a == 16'd0) ? 16'd1 : a; m_code = 3'd0; push(1, 0, 0, 0, n + 3); end
        8'h04: begin
          if (busy) begin m_code = 3'd4; push(0, 1, 0, 0, n + 3); end
          else      begin m_code = 3'd0; push(1, 0, 1, 0, n + 3); end
        end
        8'h05: begin m_code = 3'd0; push(1, 0, 0, 1, n + 3); end
        default: begin m_code = 3'd2; push(0, 1, 0, 0, n + 3); end
      endcase
    end
    finish_byte();
    drain();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic [7:0]  op, j;
    nreset = 1'b0; en = 1'b1; ready = 1'b0; capture_busy = 1'b0; rx_byte = 8'h00;
    model_reset();
    repeat (3) @(posedge rdclk);
    #1 nreset = 1'b1;
    repeat (6) @(posedge rdclk);
    #1;
    check("reset_mask",  trig_mask,  m_mask);
    check("reset_value", trig_value, m_value);
    check("reset_div",   clk_div,    m_div);
    check("reset_code",  err_code,   m_code);

    send_frame(8'h03, 16'h1234, 1, 0, 0);
    send_byte(8'h55);
    send_frame(8'h01, 16'h000F, 1, 0, 0);
    send_frame(8'h03, 16'h0000, 1, 0, 0);
    send_frame(8'h01, 16'h000F, 0, 0, 0);
    send_frame(8'h07, 16'h0000, 1, 0, 0);
    send_frame(8'h04, 16'h0000, 1, 0, 0);
    send_frame(8'h04, 16'h0000, 1, 1, 0);
    send_frame(8'h05, 16'h0000, 1, 1, 0);
    send_frame(8'h02, 16'h00AB, 1, 0, 0);

    // stall inside a frame until the inter-byte timeout expires
    send_byte(SYNC);
    raise(8'h02, n);
    m_code = 3'd3;
    push(1'b0, 1'b1, 1'b0, 1'b0, n + 2 + TMO);
    finish_byte();
    repeat (TMO + 5) @(posedge rdclk);
    drain();
    send_frame(8'h02, 16'h005A, 1, 0, 0);

    send_frame(8'h01, 16'h003C, 1, 0, 100);

    // reset mid-frame discards the partial frame
    send_byte(SYNC);
    send_byte(8'h02);
    @(posedge rdclk); #1 nreset = 1'b0;
    @(posedge rdclk); #1 nreset = 1'b1;
    model_reset();
    send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'h58);
    repeat (10) @(posedge rdclk);
    #1;
    check("after_reset_value", trig_value, m_value);
    check("after_reset_code",  err_code,   m_code);
    check("after_reset_div",   clk_div,    m_div);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        j = 8'($urandom);
        if (j == SYNC) j = 8'h00;
        send_byte(j);
      end
      op = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(1, 5)) : 8'($urandom);
      send_frame(op, 16'($urandom), $urandom_range(0, 9) < 8, 1'($urandom), 0);
    end

    repeat (10) @(posedge rdclk);
    #1;
    check("final_mask",  trig_mask,  m_mask);
    check("final_value", trig_value, m_value);
    check("final_div",   clk_div,    m_div);
    check("final_code",  err_code,   m_code);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
